// File: rtl/rps_match_host_pkg.sv
// Shared codes and bit-field positions for the rock-paper-scissors match host
// and the evaluator it drives.
package rps_match_host_pkg;

  localparam logic [1:0] MOVE_STONE    = 2'b00;
  localparam logic [1:0] MOVE_PAPER    = 2'b01;
  localparam logic [1:0] MOVE_SCISSORS = 2'b10;
  localparam logic [1:0] MOVE_INVALID  = 2'b11;

  localparam logic [1:0] WIN_TIE     = 2'b00;
  localparam logic [1:0] WIN_P1      = 2'b01;
  localparam logic [1:0] WIN_P2      = 2'b10;
  localparam logic [1:0] WIN_INVALID = 2'b11;

  localparam logic [2:0] EVAL_IDLE     = 3'b000;
  localparam logic [2:0] EVAL_EVALUATE = 3'b001;
  localparam logic [2:0] EVAL_RESULT   = 3'b010;

  // game_ui drive fields
  localparam int UI_P1_LSB    = 0;
  localparam int UI_P2_LSB    = 2;
  localparam int UI_START_BIT = 4;

  // game_status fields
  localparam int ST_DEBUG_LSB = 0;
  localparam int ST_WIN_LSB   = 3;
  localparam int ST_WIN_MSB   = 4;
  localparam int ST_STATE_LSB = 5;
  localparam int ST_STATE_MSB = 7;

  // x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register: bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } host_state_e;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/rps_match_host_lfsr_move.sv
// Free-running 8-bit LFSR producing the CPU player's move each cycle.
module rps_lfsr_move
  import rps_match_host_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] move_o
);

  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  // Only three legal moves exist, so the fourth pattern folds onto stone.
  assign move_o = (lfsr_q[1:0] == MOVE_INVALID) ? MOVE_STONE : lfsr_q[1:0];

endmodule

// File: rtl/rps_match_host.sv
// Match host: plays rounds against an external evaluator through a start /
// result / release handshake and keeps the match score.
module rps_match_host
  import rps_match_host_pkg::*;
#(
  parameter int unsigned ROUNDS_TO_WIN  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] human_move,
  input  logic       human_go,
  input  logic       new_match,
  input  logic       cpu_sel,
  input  logic [1:0] cpu_move_in,
  input  logic [7:0] game_status,
  output logic [7:0] game_ui,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] last_result,
  output logic       match_done,
  output logic [1:0] match_winner,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] WIN_SCORE = 4'(ROUNDS_TO_WIN);

  host_state_e state_q, state_d;
  logic [1:0]  p1_q, p1_d, p2_q, p2_d;
  logic        start_q, start_d;
  logic [3:0]  score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [1:0]  result_q, result_d, last_q, last_d, mwin_q, mwin_d;
  logic        done_q, done_d, terr_q, terr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  lfsr_move;
  logic [2:0]  ev_state;
  logic [3:0]  new_p1, new_p2;
  logic        unused_debug;

  rps_lfsr_move #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .move_o (lfsr_move)
  );

  assign ev_state     = game_status[ST_STATE_MSB:ST_STATE_LSB];
  assign unused_debug = ^game_status[ST_WIN_LSB-1:ST_DEBUG_LSB];

  always_comb begin
    state_d    = state_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    start_d    = start_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    result_d   = result_q;
    last_d     = last_q;
    mwin_d     = mwin_q;
    done_d     = done_q;
    terr_d     = terr_q;
    cnt_d      = cnt_q;
    new_p1     = (result_q == WIN_P1) ? sat_inc(score_p1_q) : score_p1_q;
    new_p2     = (result_q == WIN_P2) ? sat_inc(score_p2_q) : score_p2_q;

    if (new_match) begin
      state_d    = S_IDLE;
      start_d    = 1'b0;
      score_p1_d = 4'd0;
      score_p2_d = 4'd0;
      last_d     = WIN_TIE;
      mwin_d     = 2'b00;
      done_d     = 1'b0;
      terr_d     = 1'b0;
      cnt_d      = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (human_go) begin
            p1_d    = human_move;
            p2_d    = cpu_sel ? cpu_move_in : lfsr_move;
            start_d = 1'b1;
            cnt_d   = 8'd0;
            state_d = S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (ev_state == EVAL_RESULT) begin
            result_d = game_status[ST_WIN_MSB:ST_WIN_LSB];
            start_d  = 1'b0;
            cnt_d    = 8'd0;
            state_d  = S_RELEASE;
          end else if (cnt_q == TO_LAST) begin
            terr_d  = 1'b1;
            start_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_RELEASE: begin
          // Scores commit only once the evaluator has returned to idle.
          if (ev_state == EVAL_IDLE) begin
            score_p1_d = new_p1;
            score_p2_d = new_p2;
            last_d     = result_q;
            if (new_p1 == WIN_SCORE) begin
              done_d  = 1'b1;
              mwin_d  = WIN_P1;
              state_d = S_DONE;
            end else if (new_p2 == WIN_SCORE) begin
              done_d  = 1'b1;
              mwin_d  = WIN_P2;
              state_d = S_DONE;
            end else begin
              state_d = S_IDLE;
            end
          end else if (cnt_q == TO_LAST) begin
            terr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      p1_q       <= 2'b00;
      p2_q       <= 2'b00;
      start_q    <= 1'b0;
      score_p1_q <= 4'd0;
      score_p2_q <= 4'd0;
      result_q   <= WIN_TIE;
      last_q     <= WIN_TIE;
      mwin_q     <= 2'b00;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      start_q    <= start_d;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
      result_q   <= result_d;
      last_q     <= last_d;
      mwin_q     <= mwin_d;
      done_q     <= done_d;
      terr_q     <= terr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign game_ui      = {3'b000, start_q, p2_q, p1_q};
  assign score_p1     = score_p1_q;
  assign score_p2     = score_p2_q;
  assign last_result  = last_q;
  assign match_done   = done_q;
  assign match_winner = mwin_q;
  assign busy         = (state_q == S_DRIVE) || (state_q == S_RELEASE);
  assign timeout_err  = terr_q;

endmodule

// File: doc/rps_match_host.md
RPS_MATCH_HOST -- requirements
Module: rps_match_host

Interface
REQ-001 Parameter ROUNDS_TO_WIN, default 3: round wins needed to end a match (1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for each evaluator phase (1..255).
REQ-003 Parameter LFSR_SEED, default 8'hA5: nonzero reset value of the CPU-move LFSR.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 human_move  in  2  player-1 move: 00 stone, 01 paper, 10 scissors, 11 invalid (passed through).
REQ-007 human_go  in  1  one-cycle request to play a round.
REQ-008 new_match  in  1  one-cycle request to clear scores and errors.
REQ-009 cpu_sel  in  1  1 = use cpu_move_in as the player-2 move, 0 = use the LFSR move.
REQ-010 cpu_move_in  in  2  externally forced player-2 move.
REQ-011 game_status  in  8  evaluator status {state[2:0], winner[1:0], debug[2:0]}.
REQ-012 game_ui  out  8  evaluator drive: [1:0] p1 move, [3:2] p2 move, [4] start, [7:5] always 0.
REQ-013 score_p1, score_p2  out  4 each  round-win tallies.
REQ-014 last_result  out  2  winner code of the most recent completed round.
REQ-015 match_done  out  1  high once either score reaches ROUNDS_TO_WIN.
REQ-016 match_winner  out  2  01 = p1, 10 = p2, 00 while no match is done.
REQ-017 busy  out  1  high in every state except IDLE and DONE.
REQ-018 timeout_err  out  1  sticky handshake-timeout flag.

Function
REQ-019 FSM states: IDLE, DRIVE, RELEASE, DONE.
REQ-020 IDLE: on human_go, latch human_move and the player-2 move (cpu_sel mux, sampled the same cycle); go to DRIVE.
REQ-021 DRIVE: game_ui[4]=1 with the latched moves. When game_status[7:5]==3'b010, capture game_status[4:3] as the round result and go to RELEASE.
REQ-022 RELEASE: game_ui[4]=0, latched moves held. When game_status[7:5]==3'b000, update scores and go to DONE if either score equals ROUNDS_TO_WIN, else to IDLE.
REQ-023 Score update: winner 01 increments score_p1; 10 increments score_p2; 00 (tie) and 11 (invalid) leave scores unchanged. last_result takes the captured code in every case.
REQ-024 Scores saturate at 15; the match ends at ROUNDS_TO_WIN, so saturation is unreachable in normal use.
REQ-025 DONE: match_done=1 and match_winner is set; human_go is ignored; only new_match leaves DONE.
REQ-026 new_match in any state: clear scores, last_result, match_done, match_winner and timeout_err; drive game_ui[4]=0; go to IDLE next cycle. If new_match and human_go arrive together, new_match wins and human_go is dropped.
REQ-027 human_go outside IDLE is ignored (no queuing).
REQ-028 Timeout: a counter restarts on entry to DRIVE and to RELEASE. Reaching TIMEOUT_CYCLES without the awaited status sets timeout_err, drops start, and returns to IDLE with scores unchanged.
REQ-029 LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1, shift left with feedback into bit 0, advances every cycle. Its move is lfsr[1:0], with 11 mapped to 00.
REQ-030 game_ui outputs are registered; a round takes at least 4 cycles from human_go to the score update with a 1-cycle evaluator.

Reset
REQ-031 On reset: state IDLE, game_ui=8'h00, scores 0, last_result 00, match_done 0, match_winner 00, busy 0, timeout_err 0, lfsr=LFSR_SEED, timeout counter 0.
REQ-032 Reset asserted mid-round drops start immediately (asynchronously) and discards the round.

Structure
REQ-033 Shared package holds the move codes, winner codes, evaluator state codes (IDLE 000, EVALUATE 001, RESULT 010) and the game_ui/game_status bit-field positions.
REQ-034 One sub-module, rps_lfsr_move: the LFSR plus its 2-bit move mapping.

Verification
REQ-035 Bench connects the host to the evaluator; each scenario first asserts reset.
REQ-036 cpu_sel=1, cpu_move_in=10, human_move=00, human_go -> game_ui=8'h18 in DRIVE; after release score_p1=1, last_result=01.
REQ-037 Three rounds of stone vs scissors -> score_p1=3, match_done=1, match_winner=01; a further human_go leaves all outputs unchanged.
REQ-038 human_move=11 -> last_result=11; scores unchanged; FSM returns to IDLE.
REQ-039 game_status stuck at 8'h00 (evaluator absent), human_go -> timeout_err=1 after 255 cycles in DRIVE, start=0, FSM in IDLE.
REQ-040 new_match and human_go in the same cycle during DRIVE -> next cycle IDLE, start=0, scores 0, no round played.
REQ-041 Reset asserted while in RELEASE -> game_ui=8'h00 and all outputs at reset values before the next clock edge.
